// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB memory slave.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

    // Error cause bit positions within the setup-phase cause vector
    localparam int unsigned ERR_ALIGN  = 0;
    localparam int unsigned ERR_RANGE  = 1;
    localparam int unsigned ERR_WPROT  = 2;
    localparam int unsigned ERR_CAUSES = 3;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned off_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_bytemem.sv
// Word-organised RAM with per-byte write enables, asynchronous read and synchronous clear.
module apb_bytemem
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    idx,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [byte_lanes(DATA_W)-1:0] wstrb,
    output logic [DATA_W-1:0]           rdata
);

    localparam int unsigned LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] bitmask;

    // Expand byte strobes to a bit mask so the write is a single word update
    for (genvar b = 0; b < LANES; b++) begin : g_mask
        assign bitmask[b*8 +: 8] = {8{wstrb[b]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[idx] <= (mem[idx] & ~bitmask) | (wdata & bitmask);
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB memory slave: wait states, byte strobes, write-protected low region,
// error classification and a saturating error counter.
module apb_mem_slave_p
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned WAIT_CYC  = 0,
    parameter int unsigned RO_WORDS  = 0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                          pclk,
    input  logic                          prst,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDR_W-1:0]             paddr,
    input  logic [DATA_W-1:0]             pwdata,
    input  logic [byte_lanes(DATA_W)-1:0] pstrb,
    output logic                          pready,
    output logic                          pslverr,
    output logic [DATA_W-1:0]             prdata,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int unsigned LANES = byte_lanes(DATA_W);
    localparam int unsigned OFF_W = off_bits(DATA_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    apb_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q;
    logic                    write_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [LANES-1:0]        strb_q;
    logic                    err_q;
    logic                    capture, commit;

    logic [ADDR_W-1:0]       widx_in;
    logic                    ro_hit;
    logic [ERR_CAUSES-1:0]   cause;
    logic [IDX_W-1:0]        mem_idx;
    logic [DATA_W-1:0]       rdata;

    // Setup-phase address classification on the full address width (no wrap)
    assign widx_in = paddr >> OFF_W;

    if (RO_WORDS > 0) begin : g_ro
        assign ro_hit = widx_in < ADDR_W'(RO_WORDS);
    end else begin : g_no_ro
        assign ro_hit = 1'b0;
    end

    always_comb begin
        cause            = '0;
        cause[ERR_ALIGN] = (paddr & OFF_MASK) != '0;
        cause[ERR_RANGE] = widx_in >= ADDR_W'(DEPTH);
        cause[ERR_WPROT] = pwrite & ro_hit;
    end

    // Next-state logic; an access phase ends on completion or when psel drops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYC);
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                err_q   <= |cause;
            end
            if (commit && err_q && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign mem_idx = IDX_W'(addr_q >> OFF_W);

    apb_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (pclk),
        .rst   (prst),
        .we    (commit & write_q & ~err_q),
        .idx   (mem_idx),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .rdata (rdata)
    );

    assign pready  = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr = pready & err_q;
    assign prdata  = (pready && !write_q && !err_q) ? rdata : '0;

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB memory-mapped slave, the next generation of the team's APB memory slave. Adds configurable data, address and memory widths, programmable wait states, PSTRB byte enables and a write-protected low region. Adds explicit error classification (out-of-range, misaligned, write-protect) and a saturating error counter. Sits behind the APB bridge/decoder as a generic scratch or config-RAM target.

Parameters:
DATA_W, 32, data bus width in bits; one of 8, 16, 32 or 64.
ADDR_W, 32, PADDR width in bits.
DEPTH, 128, memory depth in DATA_W words; power of two.
WAIT_CYC, 0, wait states inserted in every ACCESS phase before PREADY; range 0..15.
RO_WORDS, 0, word indices 0..RO_WORDS-1 are read-only; must be no greater than DEPTH.
ERR_CNT_W, 8, width of the error counter.

Ports:
pclk  in  1  clock; all logic on rising edge.
prst  in  1  reset; synchronous, active-high.
psel  in  1  slave select.
penable  in  1  access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address.
pwdata  in  DATA_W  write data.
pstrb  in  DATA_W/8  byte write enables.
pready  out  1  transfer completes this cycle.
pslverr  out  1  error response; valid only while pready = 1.
prdata  out  DATA_W  read data; valid while pready = 1 on a read.
err_cnt  out  ERR_CNT_W  count of errored transfers; saturates at the maximum value.

Behaviour:
- Reset, sampled on pclk rising edge while prst = 1:
  - State goes to IDLE; wait counter = 0; latched address, write flag, data and strobe registers = 0.
  - All memory words cleared to 0; err_cnt = 0.
  - Outputs pready = 0, pslverr = 0, prdata = 0.
- FSM states: IDLE and ACCESS.
  - IDLE goes to ACCESS on psel & !penable (setup phase).
  - On that edge: latch paddr, pwrite, pwdata and pstrb; load wait counter with WAIT_CYC; compute the error flag.
  - In IDLE, psel & penable with no prior setup is ignored.
- ACCESS behaviour:
  - pready = (state == ACCESS) & (cnt == 0), combinational from registers.
  - If cnt != 0, cnt decrements each cycle.
  - If psel = 0 while in ACCESS, the transfer is aborted: return to IDLE, no write, no error count.
  - On the edge where pready = 1 with psel = 1, the transfer commits and the FSM returns to IDLE.
- Latency:
  - Setup plus access takes 2 + WAIT_CYC cycles (2 when WAIT_CYC = 0).
  - Back-to-back transfers: the next setup is accepted in the cycle after completion.
- Addressing:
  - Word index = paddr >> log2(DATA_W/8).
  - Error flag is set if any of the following holds:
    - any byte-offset bit of paddr is nonzero (misaligned);
    - word index >= DEPTH, evaluated on the full address width with no wrap-around;
    - pwrite = 1 and word index < RO_WORDS.
- Write commit:
  - On a non-error commit, byte lane i of mem[index] takes pwdata byte i when pstrb[i] = 1.
  - pstrb = 0 is a legal no-op write.
- Read data:
  - prdata = mem[index] when pready & !pwrite & !err; otherwise prdata = 0 (never X).
- Errors:
  - pslverr = pready & err.
  - An errored write leaves memory unchanged; an errored read returns 0.
  - err_cnt increments by 1 on each errored commit and saturates at all-ones.
- Reset mid-transfer: the transfer is dropped, no write occurs, and pready stays 0 on the following cycle.
- Inputs are sampled only at the setup edge. Changes to paddr, pwdata, pstrb or pwrite during ACCESS are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_state_t;
  - localparam byte-lane and offset-width helper functions;
  - error-cause localparams.
- One natural sub-module: apb_bytemem, a DEPTH x DATA_W array with per-byte write enables, an asynchronous read port and a synchronous clear on prst.

Test Plan:
Bench configuration for all scenarios: DATA_W=32, DEPTH=128, WAIT_CYC=2, RO_WORDS=4.
1. Write 0xDEADBEEF to 0x40 with pstrb=0xF, then read 0x40 -> pready is low for 2 access cycles and high in the 3rd; prdata=0xDEADBEEF; pslverr=0.
2. Write 0x11223344 to 0x40 with pstrb=0b0101, then read 0x40 -> prdata=0xDE22BE44.
3. Read 0x200 (word 128) -> pready with pslverr=1; prdata=0; err_cnt=1. Write 0x41 (misaligned) -> pslverr=1; err_cnt=2.
4. Write 0xFFFFFFFF to 0x08 (word 2, read-only) -> pslverr=1; a subsequent read of 0x08 returns 0 (reset value); readback from 0x08 succeeds with pslverr=0.
5. Drop psel during the 1st wait cycle of a write of 0xCAFEF00D to 0x44 -> FSM returns to IDLE; a read of 0x44 returns 0; err_cnt is unchanged.
6. Assert prst during the wait phase of a read -> next cycle pready=0, prdata=0, err_cnt=0, mem[0x40]=0. Separately, 300 errored reads -> err_cnt holds at 255.
